cipher_ctrl: RTL and testbench
==============================

# cipher_ctrl

Responder-side controller for the EN/Krdy/Drdy cipher handshake. It latches a key on Krdy, then latches a data block on Drdy. It runs a fixed iterated round transform over the block and returns the result with a one-cycle Dvld strobe. It sits between the host-side request logic, which drives EN/Krdy/Drdy, and downstream consumers of Dout.

## Interface
- W, 32: key, data and result width in bits (W ≥ 8).
- ROUNDS, 10: number of round iterations (1 to 255).
- CLK  in  1  clock; all state changes on the rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- EN  in  1  interface enable; qualifies Krdy and Drdy.
- Krdy  in  1  key-ready strobe.
- Kin  in  W  key value, sampled with Krdy.
- Drdy  in  1  data-ready strobe.
- Din  in  W  data block, sampled with Drdy.
- Dout  out  W  result; holds its value until the next completion.
- Kvld  out  1  one-cycle pulse: key accepted.
- Dvld  out  1  one-cycle pulse: Dout updated.
- BSY  out  1  high while rounds are in progress.

## Operation
- States:
  - NOKEY: reset state.
  - KEYED: key held, idle.
  - RUN: rounds in progress.
- Key acceptance (accept_k):
  - Condition: EN & Krdy at an edge, in NOKEY or KEYED.
  - Action: key <= Kin, state -> KEYED, Kvld = 1 for the next cycle.
  - In RUN, Krdy is ignored and the key is unchanged.
- Data acceptance (accept_d):
  - Condition: EN & Drdy & ~Krdy at an edge, in KEYED only.
  - Action: s <= Din ^ key, r <= 0, state -> RUN.
  - Drdy is ignored in NOKEY and in RUN.
- Simultaneous Krdy and Drdy: the key is accepted and the data is dropped.
- Round r, for r = 0 to ROUNDS-1, one round per RUN edge:
  - rk = rotl(key, r mod W) ^ r, with r zero-extended to W bits.
  - s <= rotl(s ^ rk, 5) + rk, modulo 2^W.
  - r increments by 1.
- Completion: on the edge that executes round ROUNDS-1:
  - Dout <= new s.
  - Dvld = 1 for one cycle.
  - state -> KEYED; the key is retained.
- The round counter is 8 bits and never wraps; ROUNDS ≤ 255 is enforced.

## Timing
- Reset values:
  - Dout = 0, Kvld = 0, Dvld = 0, BSY = 0.
  - Internal state: key = 0, s = 0, r = 0, state NOKEY.
- Kvld is high in the cycle after the accept_k edge.
- BSY is high from the cycle after the accept_d edge until the completion edge.
- BSY = (state == RUN).
- Latency: Dvld is high exactly ROUNDS cycles after the accept_d edge, when there are no stalls.
- Dvld and BSY are never high together.
- Back-to-back operation: accept_d is legal in the Dvld cycle, because the state is already KEYED. Result throughput is one block per ROUNDS+1 cycles.
- Reset mid-operation:
  - All outputs clear immediately.
  - The key is invalidated (state NOKEY).
  - No Dvld is produced for the aborted block.
- A new key is accepted in the Dvld cycle. It takes effect for the next block only.

## Configuration
- CIPHER_CTRL_STALL_EN defined:
  - EN low in RUN freezes s and r, and BSY stays high.
  - Completion is delayed by the number of EN-low cycles.
- CIPHER_CTRL_STALL_EN undefined:
  - EN gates only Krdy and Drdy sampling.
  - Rounds run freely, so latency is always ROUNDS.

## Test plan
- ROUNDS=1, Kin=0x00000001 then Din=0x00000000 → Kvld pulses after the key edge; Dout=0x00000001, with Dvld one cycle after the accept_d edge.
- ROUNDS=2, same key and data → Dout=0x00000043; BSY high for exactly 2 cycles; Dvld high 2 cycles after accept_d.
- Drdy with no key loaded, then Krdy and Drdy in the same cycle → no BSY and no Dvld in either case; Kvld pulses once.
- ROUNDS=10: reset pulsed at round 4, then Drdy → outputs are 0 immediately; the following Drdy is ignored (NOKEY); Dvld never asserts.
- ROUNDS=2 with the stall macro, EN=0 for 3 cycles during RUN → Dvld arrives 5 cycles after accept_d with Dout=0x00000043. Without the macro, Dvld arrives after 2 cycles.
- Krdy with a new key during RUN, then a second Drdy in the Dvld cycle → the first result uses the old key; the second block is accepted immediately and also uses the old key, since the ignored Krdy did not change it.

Source files
------------

// File: rtl/cipher_ctrl.sv
// Responder-side EN/Krdy/Drdy cipher controller: latches a key, then runs ROUNDS iterations over a data block.
// Optional build macro CIPHER_CTRL_STALL_EN: EN low during RUN freezes the round state.

module cipher_ctrl #(
    parameter int W      = 32,
    parameter int ROUNDS = 10
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         EN,
    input  logic         Krdy,
    input  logic [W-1:0] Kin,
    input  logic         Drdy,
    input  logic [W-1:0] Din,
    output logic [W-1:0] Dout,
    output logic         Kvld,
    output logic         Dvld,
    output logic         BSY
);

    // state | meaning
    // NOKEY | reset state, no key held
    // KEYED | key held, idle, ready for data
    // RUN   | rounds in progress
    typedef enum logic [1:0] {
        NOKEY = 2'd0,
        KEYED = 2'd1,
        RUN   = 2'd2
    } state_t;

    if (ROUNDS < 1 || ROUNDS > 255) begin : g_rounds_check
        $error("cipher_ctrl: ROUNDS must be in 1..255");
    end

    if (W < 8) begin : g_width_check
        $error("cipher_ctrl: W must be at least 8");
    end

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int n);
        // (W - n) % W keeps the right shift at 0 when n is 0, so no special case is needed
        return (x << n) | (x >> ((W - n) % W));
    endfunction

    state_t         state_q, state_d;
    logic [W-1:0]   key_q, key_d;
    logic [W-1:0]   s_q, s_d;
    logic [7:0]     r_q, r_d;
    logic [W-1:0]   dout_q, dout_d;
    logic           kvld_q, kvld_d;
    logic           dvld_q, dvld_d;

    logic           run_en;
    logic [W-1:0]   rk;
    logic [W-1:0]   s_round;
    logic           last_round;
    int             rot_amt;

`ifdef CIPHER_CTRL_STALL_EN
    assign run_en = EN;
`else
    assign run_en = 1'b1;
`endif

    always_comb begin
        rot_amt    = int'(r_q) % W;
        rk         = rotl(key_q, rot_amt) ^ W'(r_q);
        s_round    = rotl(s_q ^ rk, 5) + rk;
        last_round = (r_q == 8'(ROUNDS - 1));
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        s_d     = s_q;
        r_d     = r_q;
        dout_d  = dout_q;
        kvld_d  = 1'b0;
        dvld_d  = 1'b0;

        case (state_q)
            NOKEY: begin
                if (EN && Krdy) begin
                    key_d   = Kin;
                    kvld_d  = 1'b1;
                    state_d = KEYED;
                end
            end
            KEYED: begin
                // Krdy wins over a simultaneous Drdy; the data block is dropped
                if (EN && Krdy) begin
                    key_d   = Kin;
                    kvld_d  = 1'b1;
                end else if (EN && Drdy) begin
                    s_d     = Din ^ key_q;
                    r_d     = 8'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (run_en) begin
                    s_d = s_round;
                    r_d = r_q + 8'd1;
                    if (last_round) begin
                        dout_d  = s_round;
                        dvld_d  = 1'b1;
                        state_d = KEYED;
                    end
                end
            end
            default: begin
                state_d = NOKEY;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= NOKEY;
            key_q   <= '0;
            s_q     <= '0;
            r_q     <= '0;
            dout_q  <= '0;
            kvld_q  <= 1'b0;
            dvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            s_q     <= s_d;
            r_q     <= r_d;
            dout_q  <= dout_d;
            kvld_q  <= kvld_d;
            dvld_q  <= dvld_d;
        end
    end

    assign Dout = dout_q;
    assign Kvld = kvld_q;
    assign Dvld = dvld_q;
    assign BSY  = (state_q == RUN);

endmodule

// File: tb/tb_cipher_ctrl.sv
// Self-checking bench for cipher_ctrl: a ROUNDS=2 unit under table vectors with a result scoreboard,
// plus ROUNDS=1 and ROUNDS=10 units sharing a second input bundle for latency and reset-abort sequences.

module tb_cipher_ctrl;

    localparam int RA = 2;

`ifdef CIPHER_CTRL_STALL_EN
    localparam int STALL_CYC = 3;
`else
    localparam int STALL_CYC = 0;
`endif

    logic        CLK;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    logic        a_rstn, a_en, a_krdy, a_drdy;
    logic [31:0] a_kin, a_din, a_dout;
    logic        a_kvld, a_dvld, a_bsy;

    logic        b_rstn, b_en, b_krdy, b_drdy;
    logic [31:0] b_kin, b_din;
    logic [31:0] b1_dout, b10_dout;
    logic        b1_kvld, b1_dvld, b1_bsy;
    logic        b10_kvld, b10_dvld, b10_bsy;

    cipher_ctrl #(.W(32), .ROUNDS(RA)) u_dut2 (
        .CLK(CLK), .RSTn(a_rstn), .EN(a_en), .Krdy(a_krdy), .Kin(a_kin),
        .Drdy(a_drdy), .Din(a_din), .Dout(a_dout), .Kvld(a_kvld), .Dvld(a_dvld), .BSY(a_bsy)
    );

    cipher_ctrl #(.W(32), .ROUNDS(1)) u_dut1 (
        .CLK(CLK), .RSTn(b_rstn), .EN(b_en), .Krdy(b_krdy), .Kin(b_kin),
        .Drdy(b_drdy), .Din(b_din), .Dout(b1_dout), .Kvld(b1_kvld), .Dvld(b1_dvld), .BSY(b1_bsy)
    );

    cipher_ctrl #(.W(32), .ROUNDS(10)) u_dut10 (
        .CLK(CLK), .RSTn(b_rstn), .EN(b_en), .Krdy(b_krdy), .Kin(b_kin),
        .Drdy(b_drdy), .Din(b_din), .Dout(b10_dout), .Kvld(b10_kvld), .Dvld(b10_dvld), .BSY(b10_bsy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        if (n == 0) return x;
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] model(input logic [31:0] k, input logic [31:0] d, input int rounds);
        logic [31:0] s, rk;
        s = d ^ k;
        for (int r = 0; r < rounds; r++) begin
            rk = rol(k, r % 32) ^ 32'(r);
            s  = rol(s ^ rk, 5) + rk;
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] dout;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    // Result monitor for the ROUNDS=2 unit
    always @(negedge CLK) begin
        if (a_rstn && a_dvld) begin
            check("dvld_bsy_exclusive", 32'(a_bsy), 32'd0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_dvld: got dout 0x%08h with no result pending", a_dout);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_dout", a_dout, e.dout);
                check("result_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    typedef struct {
        logic [31:0] kin;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    vec_t        vec[4];
    logic [31:0] key_a;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_key_a(input logic [31:0] k);
        a_krdy = 1'b1;
        a_kin  = k;
        tick();
        a_krdy = 1'b0;
        check("kvld_pulse", 32'(a_kvld), 32'd1);
        tick();
        check("kvld_one_cycle", 32'(a_kvld), 32'd0);
        key_a = k;
    endtask

    // Drives one Drdy cycle; returns just after the accept edge
    task automatic send_a(input logic [31:0] d, input logic [31:0] exp, input int extra);
        exp_t e;
        a_drdy = 1'b1;
        a_din  = d;
        e.dout = exp;
        e.cyc  = cyc + 1 + RA + extra;
        sb.push_back(e);
        tick();
        a_drdy = 1'b0;
    endtask

    initial begin
        int kv, bs, dv;

        vec[0] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0043};
        vec[1] = '{32'hDEAD_BEEF, 32'h0123_4567, model(32'hDEAD_BEEF, 32'h0123_4567, RA)};
        vec[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, model(32'hFFFF_FFFF, 32'hFFFF_FFFF, RA)};
        vec[3] = '{32'h8000_0000, 32'hA5A5_5A5A, model(32'h8000_0000, 32'hA5A5_5A5A, RA)};

        a_rstn = 1'b0; a_en = 1'b1; a_krdy = 1'b0; a_drdy = 1'b0; a_kin = '0; a_din = '0;
        b_rstn = 1'b0; b_en = 1'b1; b_krdy = 1'b0; b_drdy = 1'b0; b_kin = '0; b_din = '0;
        key_a  = '0;
        repeat (3) tick();
        check("reset_dout", a_dout, 32'd0);
        check("reset_kvld", 32'(a_kvld), 32'd0);
        check("reset_dvld", 32'(a_dvld), 32'd0);
        check("reset_bsy", 32'(a_bsy), 32'd0);
        a_rstn = 1'b1;
        b_rstn = 1'b1;
        tick();

        // Drdy with no key loaded is ignored
        bs = 0;
        a_drdy = 1'b1;
        a_din  = 32'h1111_2222;
        tick();
        bs += a_bsy;
        a_drdy = 1'b0;
        repeat (5) begin tick(); bs += a_bsy; end
        check("nokey_drdy_bsy", 32'(bs), 32'd0);

        // Krdy and Drdy together: key taken, data dropped
        kv = 0; bs = 0;
        a_krdy = 1'b1; a_kin = 32'h0BAD_F00D;
        a_drdy = 1'b1; a_din = 32'h3333_4444;
        tick();
        kv += a_kvld; bs += a_bsy;
        a_krdy = 1'b0; a_drdy = 1'b0;
        repeat (5) begin tick(); kv += a_kvld; bs += a_bsy; end
        check("simul_kvld_count", 32'(kv), 32'd1);
        check("simul_bsy", 32'(bs), 32'd0);
        key_a = 32'h0BAD_F00D;

        for (int i = 0; i < 4; i++) begin
            load_key_a(vec[i].kin);
            send_a(vec[i].din, vec[i].exp, 0);
            bs = a_bsy;
            repeat (4) begin tick(); bs += a_bsy; end
            check("bsy_cycles", 32'(bs), 32'(RA));
        end

        // EN dropped for three cycles in RUN
        load_key_a(32'h0000_0001);
        send_a(32'h0000_0000, 32'h0000_0043, STALL_CYC);
        a_en = 1'b0;
        repeat (3) tick();
        a_en = 1'b1;
        repeat (6) tick();

        // Krdy during RUN is ignored; Drdy in the Dvld cycle is accepted with the old key
        send_a(32'hCAFE_0001, model(key_a, 32'hCAFE_0001, RA), 0);
        a_krdy = 1'b1;
        a_kin  = 32'h7777_7777;
        tick();
        a_krdy = 1'b0;
        check("run_krdy_ignored", 32'(a_kvld), 32'd0);
        tick();
        check("dvld_cycle_seen", 32'(a_dvld), 32'd1);
        send_a(32'hCAFE_0002, model(key_a, 32'hCAFE_0002, RA), 0);
        repeat (2) tick();
        check("b2b_dvld", 32'(a_dvld), 32'd1);

        // New key in the Dvld cycle applies to the next block
        a_krdy = 1'b1;
        a_kin  = 32'h1357_9BDF;
        tick();
        a_krdy = 1'b0;
        check("dvld_cycle_kvld", 32'(a_kvld), 32'd1);
        key_a = 32'h1357_9BDF;
        tick();
        send_a(32'h2468_ACE0, model(key_a, 32'h2468_ACE0, RA), 0);
        repeat (8) tick();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        // ROUNDS=1 and ROUNDS=10 units
        b_krdy = 1'b1;
        b_kin  = 32'h0000_0001;
        tick();
        b_krdy = 1'b0;
        check("r1_kvld", 32'(b1_kvld), 32'd1);
        tick();
        b_drdy = 1'b1;
        b_din  = 32'h0000_0000;
        tick();
        b_drdy = 1'b0;
        check("r1_bsy", 32'(b1_bsy), 32'd1);
        tick();
        check("r1_dvld", 32'(b1_dvld), 32'd1);
        check("r1_dout", b1_dout, 32'h0000_0001);
        repeat (9) tick();
        check("r10_dvld", 32'(b10_dvld), 32'd1);
        check("r10_dout", b10_dout, model(32'h0000_0001, 32'h0000_0000, 10));

        tick();
        b_drdy = 1'b1;
        b_din  = 32'h1234_5678;
        tick();
        b_drdy = 1'b0;
        repeat (4) tick();
        check("r10_busy_before_abort", 32'(b10_bsy), 32'd1);
        b_rstn = 1'b0;
        #1;
        check("abort_dout", b10_dout, 32'd0);
        check("abort_bsy", 32'(b10_bsy), 32'd0);
        check("abort_r1_dout", b1_dout, 32'd0);
        @(negedge CLK);
        b_rstn = 1'b1;
        tick();
        bs = 0; dv = 0;
        b_drdy = 1'b1;
        b_din  = 32'h5555_AAAA;
        tick();
        bs += b10_bsy; dv += b10_dvld;
        b_drdy = 1'b0;
        repeat (14) begin tick(); bs += b10_bsy; dv += b10_dvld; end
        check("post_reset_bsy", 32'(bs), 32'd0);
        check("post_reset_dvld", 32'(dv), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
